// File: rtl/wb_writer_pkg.sv
// Shared widths, the x0 constant and the load-buffer entry type for the writeback stage.
package wb_writer_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_rd(input logic [AW-1:0] rd);
    return rd == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small load-return FIFO; every entry carries a valid bit that a newer ALU write
// to the same register can clear, so stale load data is dropped at pop time.
module wb_fifo
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [AW-1:0]   push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            inv_en,
  input  logic [AW-1:0]   inv_rd,
  output wb_entry_t       head,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t        mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic [PW:0]      count_next;
  logic [DEPTH-1:0] inv_hit;
  logic             push_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_inv
      assign inv_hit[gi] = inv_en && (mem_reg[gi].rd == inv_rd);
    end
  endgenerate

  // A load arriving alongside a winning ALU write to the same rd is older data.
  assign push_valid = !(inv_en && (push_rd == inv_rd));

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (PW+1)'(1);
    else if (!push && pop)
      count_next = count_reg - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_reg == PW'(i)))
          mem_reg[i] <= '{valid: push_valid, rd: push_rd, data: push_data};
        else if (inv_hit[i])
          mem_reg[i].valid <= 1'b0;
      end
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PW+1)'(DEPTH));

endmodule

// File: rtl/wb_writer.sv
// Writeback write-port driver: ALU results take priority, load returns are
// buffered when they lose, and the register-file port is driven from flops.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            we,
  output logic [AW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_byp,
  output logic            rs2_byp,
  output logic [XLEN-1:0] byp_data,
  output logic            busy
);

  wb_entry_t       head;
  logic            buf_empty;
  logic            buf_full;
  logic            mem_acc;
  logic            alu_win;
  logic            buf_sel;
  logic            direct;
  logic            push;

  logic            we_reg,   we_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [XLEN-1:0] data_reg, data_next;

  assign mem_ready = !buf_full;
  assign mem_acc   = mem_valid && mem_ready;
  assign alu_win   = alu_valid && !is_zero_rd(alu_rd);
  assign buf_sel   = !alu_win && !buf_empty;
  assign direct    = !alu_win && buf_empty && mem_acc && !is_zero_rd(mem_rd);
  // x0 loads are accepted and silently dropped.
  assign push      = mem_acc && !is_zero_rd(mem_rd) && !direct;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (mem_rd),
    .push_data (mem_data),
    .pop       (buf_sel),
    .inv_en    (alu_win),
    .inv_rd    (alu_rd),
    .head      (head),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  always_comb begin
    we_next   = 1'b0;
    addr_next = addr_reg;
    data_next = data_reg;
    if (alu_win) begin
      we_next   = 1'b1;
      addr_next = alu_rd;
      data_next = alu_data;
    end else if (buf_sel) begin
      // An invalidated head still pops but writes nothing.
      if (head.valid) begin
        we_next   = 1'b1;
        addr_next = head.rd;
        data_next = head.data;
      end
    end else if (direct) begin
      we_next   = 1'b1;
      addr_next = mem_rd;
      data_next = mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      we_reg   <= we_next;
      addr_reg <= addr_next;
      data_reg <= data_next;
    end
  end

  assign we       = we_reg;
  assign wb_addr  = addr_reg;
  assign wb_data  = data_reg;
  assign byp_data = data_reg;
  assign rs1_byp  = we_reg && (addr_reg == rs1_addr) && !is_zero_rd(rs1_addr);
  assign rs2_byp  = we_reg && (addr_reg == rs2_addr) && !is_zero_rd(rs2_addr);
  assign busy     = we_reg || !buf_empty;

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: one task per scenario, expected values hand-derived.
module tb_wb_writer;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_byp;
  logic        rs2_byp;
  logic [31:0] byp_data;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  wb_writer #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .we        (we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_byp   (rs1_byp),
    .rs2_byp   (rs2_byp),
    .byp_data  (byp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per register-file write.
  always @(posedge clk) begin
    #1;
    if (we === 1'b1)
      $display("[%0t] write r%0d = 0x%08h", $time, wb_addr, wb_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    rs1_addr = '0;
    rs2_addr = '0;
    step();
    step();
    total_cnt++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else pass_cnt++;
    total_cnt++; if (wb_addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", wb_addr); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'd0) $display("FAIL reset_data: got %h want 0", wb_data); else pass_cnt++;
    total_cnt++; if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready: got %b want 1", mem_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if ({rs1_byp, rs2_byp} !== 2'b00) $display("FAIL reset_byp: got %b want 00", {rs1_byp, rs2_byp}); else pass_cnt++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    total_cnt++; if (we !== 1'b1) $display("FAIL alu_we: got %b want 1", we); else pass_cnt++;
    total_cnt++; if (wb_addr !== 5'd5) $display("FAIL alu_addr: got %0d want 5", wb_addr); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'hDEADBEEF) $display("FAIL alu_data: got %h want deadbeef", wb_data); else pass_cnt++;
    step();
    total_cnt++; if (we !== 1'b0) $display("FAIL alu_we_once: got %b want 0", we); else pass_cnt++;
    total_cnt++; if (wb_addr !== 5'd5) $display("FAIL alu_addr_hold: got %0d want 5", wb_addr); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL alu_busy_idle: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_x0_drop();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h55;
    #1;
    total_cnt++; if (mem_ready !== 1'b1) $display("FAIL x0_mem_ready: got %b want 1", mem_ready); else pass_cnt++;
    step();
    idle_inputs();
    total_cnt++; if (we !== 1'b1) $display("FAIL x0_we: got %b want 1", we); else pass_cnt++;
    total_cnt++; if (wb_addr !== 5'd3) $display("FAIL x0_addr: got %0d want 3", wb_addr); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'h55) $display("FAIL x0_data: got %h want 55", wb_data); else pass_cnt++;
    step();
    total_cnt++; if (we !== 1'b0) $display("FAIL x0_no_second: got %b want 0", we); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL x0_buf_empty: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_alu_stream();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(11 + i);
      alu_data  = 32'h100 + 32'(i);
      mem_valid = (i < 2);
      mem_rd    = (i == 0) ? 5'd7 : 5'd8;
      mem_data  = (i == 0) ? 32'h77 : 32'h88;
      step();
      total_cnt++; if (wb_addr !== 5'(11 + i) || we !== 1'b1) $display("FAIL stream_alu%0d: got we=%b r%0d want we=1 r%0d", i, we, wb_addr, 11 + i); else pass_cnt++;
      if (i >= 1) begin
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL stream_full%0d: got mem_ready=%b want 0", i, mem_ready); else pass_cnt++;
      end
    end
    idle_inputs();
    step();
    total_cnt++; if (we !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'h77) $display("FAIL stream_r7: got we=%b r%0d=%h want we=1 r7=77", we, wb_addr, wb_data); else pass_cnt++;
    total_cnt++; if (mem_ready !== 1'b1) $display("FAIL stream_ready: got %b want 1", mem_ready); else pass_cnt++;
    step();
    total_cnt++; if (we !== 1'b1 || wb_addr !== 5'd8 || wb_data !== 32'h88) $display("FAIL stream_r8: got we=%b r%0d=%h want we=1 r8=88", we, wb_addr, wb_data); else pass_cnt++;
    step();
    total_cnt++; if (we !== 1'b0 || busy !== 1'b0) $display("FAIL stream_drain: got we=%b busy=%b want 0 0", we, busy); else pass_cnt++;
  endtask

  task automatic test_invalidate();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hAA;
    step();
    total_cnt++; if (we !== 1'b1 || wb_addr !== 5'd1) $display("FAIL inv_r1: got we=%b r%0d want we=1 r1", we, wb_addr); else pass_cnt++;
    mem_valid = 1'b0;
    alu_rd = 5'd9; alu_data = 32'hBB;
    step();
    idle_inputs();
    total_cnt++; if (we !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'hBB) $display("FAIL inv_r9: got we=%b r%0d=%h want we=1 r9=bb", we, wb_addr, wb_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL inv_busy: got %b want 1", busy); else pass_cnt++;
    step();
    total_cnt++; if (we !== 1'b0) $display("FAIL inv_dropped: got we=%b r%0d=%h want we=0", we, wb_addr, wb_data); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'hBB) $display("FAIL inv_hold: got %h want bb", wb_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL inv_empty: got %b want 0", busy); else pass_cnt++;
    step();
    total_cnt++; if (we !== 1'b0) $display("FAIL inv_no_late: got %b want 0", we); else pass_cnt++;
  endtask

  task automatic test_bypass();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444;
    step();
    idle_inputs();
    rs1_addr = 5'd4; rs2_addr = 5'd0;
    #1;
    total_cnt++; if (rs1_byp !== 1'b1) $display("FAIL byp_rs1: got %b want 1", rs1_byp); else pass_cnt++;
    total_cnt++; if (rs2_byp !== 1'b0) $display("FAIL byp_rs2_x0: got %b want 0", rs2_byp); else pass_cnt++;
    total_cnt++; if (byp_data !== 32'h4444) $display("FAIL byp_data: got %h want 4444", byp_data); else pass_cnt++;
    rs1_addr = 5'd5; rs2_addr = 5'd4;
    #1;
    total_cnt++; if ({rs1_byp, rs2_byp} !== 2'b01) $display("FAIL byp_swap: got %b want 01", {rs1_byp, rs2_byp}); else pass_cnt++;
    step();
    total_cnt++; if (rs2_byp !== 1'b0) $display("FAIL byp_no_we: got %b want 0", rs2_byp); else pass_cnt++;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'hA0;
    step();
    alu_rd = 5'd2; alu_data = 32'h2;
    mem_rd = 5'd21; mem_data = 32'hA1;
    step();
    idle_inputs();
    total_cnt++; if (we !== 1'b1 || mem_ready !== 1'b0) $display("FAIL rstmid_pre: got we=%b mem_ready=%b want 1 0", we, mem_ready); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (we !== 1'b0) $display("FAIL rstmid_we: got %b want 0", we); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (mem_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", mem_ready); else pass_cnt++;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (we !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_after%0d: got we=%b busy=%b want 0 0", i, we, busy); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_x0_drop();
    test_alu_stream();
    test_invalidate();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
# wb_writer

Writeback-stage write-port driver for the 32x32 integer register file (synchronous write, asynchronous read). Merges single-cycle ALU results with handshaked load returns and buffers loads that lose arbitration. Drives the register file's single write port from registered outputs, never writes x0, and provides same-cycle bypass hits for the decode-stage read ports.

## Interface
- XLEN, 32, data width
- AW, 5, register address width
- DEPTH, 2, load buffer entries (power of 2, >=2)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  load return offered
- mem_ready  out  1  load return accepted when mem_valid && mem_ready
- mem_rd  in  AW  load destination
- mem_data  in  XLEN  load data
- we  out  1  register-file write enable
- wb_addr  out  AW  register-file write address
- wb_data  out  XLEN  register-file write data
- rs1_addr, rs2_addr  in  AW each  decode read addresses
- rs1_byp, rs2_byp  out  1 each  bypass hit for rs1/rs2
- byp_data  out  XLEN  bypass value (= wb_data)
- busy  out  1  buffer non-empty or we high

## Operation
- Load buffer: FIFO of DEPTH {rd, data} entries; mem_ready = !full (combinational from count).
- Each cycle exactly one candidate is selected for the write port:
  - alu_valid && alu_rd != 0 -> ALU wins.
  - else buffer non-empty -> buffer head (popped).
  - else accepted load this cycle with rd != 0 -> taken directly, not enqueued.
  - else no write.
- Accepted loads not taken directly are enqueued; push and pop in the same cycle are legal, including when full (pop frees the slot, mem_ready still reflects pre-pop full).
- ALU or load with rd == 0 is consumed and discarded; never produces we.
- Loads with rd == 0 are accepted but not enqueued.
- Ordering: when ALU wins with rd = R, every valid buffer entry with rd == R is invalidated (dropped at pop time without a write); newer ALU value must not be overwritten by older load data.
- Selected candidate is registered into we/wb_addr/wb_data; with no candidate, we = 0, addr/data hold.
- rsN_byp = we && wb_addr == rsN_addr && rsN_addr != 0 (combinational).
- busy = we || count != 0.

## Timing
- Reset values: we=0, wb_addr=0, wb_data=0, buffer empty, mem_ready=1, rs1_byp=rs2_byp=0, busy=0.
- ALU result in cycle N -> we high in N+1 -> register file updated at end of N+1.
- Load accepted into empty buffer with no ALU in cycle N -> write in N+1.
- Buffered load: written the first cycle with no competing ALU write; worst-case latency unbounded under continuous ALU traffic (upstream guarantees gaps).
- Invalidated entries consume a pop cycle but produce no write.
- Reset asserted mid-operation: buffered loads lost, we drops asynchronously; no partial write issued.

## Structure
- Shared package: XLEN, AW, REG_ZERO constant, wb_entry_t struct {valid, rd, data}.
- One sub-module: wb_fifo (DEPTH-entry FIFO with per-entry valid bits and parallel rd-match invalidate port); arbitration and output registers in wb_writer.

## Test plan
- ALU rd=5 data=0xDEADBEEF at cycle 1 -> we=1, wb_addr=5, wb_data=0xDEADBEEF at cycle 2, only that cycle.
- ALU rd=0 data=0x1234 plus load rd=3 data=0x55 same cycle -> x0 dropped, next cycle we writes r3=0x55, buffer stays empty.
- ALU every cycle 4 cycles, loads rd=7, rd=8 offered -> both enqueued, mem_ready=0 once full, writes r7 then r8 in the two cycles after ALU stops, in order.
- Load rd=9=0xAA buffered, then ALU rd=9=0xBB -> only r9=0xBB written, no later r9 write.
- we=1 wb_addr=4, rs1_addr=4, rs2_addr=0 -> rs1_byp=1, rs2_byp=0, byp_data=wb_data.
- Reset low with two buffered loads -> we, busy drop immediately; after release mem_ready=1 and no writes occur.
